// File: rtl/ram_fifo_ctrl.sv
// Stream-to-RAM FIFO controller for a single-port 16x8 RAM.
// Accepts a valid/ready byte stream, stores it in the RAM, and reads bytes
// back in order into a one-entry output register. Reads win the RAM port.
module ram_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW:0]   DEPTH   = (AW + 1)'(2 ** AW);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          rd_pend;

    logic pop;
    logic rd_grant;
    logic wr_grant;

    // Port arbitration: a read is issued whenever one is due and the output
    // register will be free to receive it; writes take the remaining cycles.
    always_comb begin
        pop       = out_valid & out_ready;
        rd_grant  = !rd_pend & (ram_cnt != '0) & (!out_valid | pop);
        in_ready  = !reset & (ram_cnt != DEPTH) & !rd_grant;
        wr_grant  = in_valid & in_ready;
        ram_we    = wr_grant;
        ram_addr  = rd_grant ? rd_ptr : wr_ptr;
        ram_wdata = in_data;
        full      = (ram_cnt == DEPTH);
        count     = ram_cnt + {{AW{1'b0}}, rd_pend} + {{AW{1'b0}}, out_valid};
        empty     = (count == '0);
    end

    // Pointer/occupancy bookkeeping and output register capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            rd_pend <= rd_grant;
            if (rd_grant) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                ram_cnt <= ram_cnt - CNT_ONE;
            end else if (wr_grant) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                ram_cnt <= ram_cnt + CNT_ONE;
            end
            // A pending read refills the register even in the cycle it is popped.
            if (rd_pend) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 16x8 RAM.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes resident in RAM, one in-flight read,
    // the output slot, running totals for addresses, and the expected stream.
    logic [7:0] m_ram[$];
    logic [7:0] m_stream[$];
    bit         m_pend;
    logic [7:0] m_pend_data;
    bit         m_ov;
    logic [7:0] m_od;
    int         wr_total;
    int         rd_total;

    ram_fifo_ctrl #(.DW(8), .AW(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: synchronous write, registered read when not writing.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_ram.delete();
        m_stream.delete();
        m_pend = 0; m_pend_data = '0; m_ov = 0; m_od = '0;
        wr_total = 0; rd_total = 0;
    endfunction

    // One clock cycle: drive inputs, check at negedge, advance model at posedge.
    task automatic step(input bit iv, input logic [7:0] d, input bit ordy, output bit acc);
        bit pop, rdg, rdy, wrg;
        int occ;
        in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        occ = m_ram.size();
        pop = m_ov && ordy;
        rdg = !m_pend && occ > 0 && (!m_ov || pop);
        rdy = (occ != 16) && !rdg;
        wrg = iv && rdy;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("ram_we", 32'(ram_we), 32'(wrg));
        chk("ram_addr", 32'(ram_addr), rdg ? 32'(rd_total % 16) : 32'(wr_total % 16));
        chk("ram_wdata", 32'(ram_wdata), 32'(d));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("count", 32'(count), 32'(occ + int'(m_pend) + int'(m_ov)));
        chk("full", 32'(full), 32'(occ == 16));
        chk("empty", 32'(empty), 32'(occ + int'(m_pend) + int'(m_ov) == 0));
        if (out_valid && ordy) begin
            if (m_stream.size() == 0) chk("pop_underflow", 32'(1), 32'(0));
            else chk("stream_order", 32'(out_data), 32'(m_stream.pop_front()));
        end
        acc = wrg;
        @(posedge clk);
        if (m_pend) begin m_ov = 1; m_od = m_pend_data; end
        else if (pop) m_ov = 0;
        if (rdg) begin m_pend_data = m_ram.pop_front(); rd_total++; end
        m_pend = rdg;
        if (wrg) begin m_ram.push_back(d); m_stream.push_back(d); wr_total++; end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // Offer one byte until accepted, bounded.
    task automatic push(input logic [7:0] d, input bit ordy);
        bit acc;
        acc = 0;
        for (int t = 0; t < 50 && !acc; t++) step(1'b1, d, ordy, acc);
        if (!acc) chk("push_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, acc);
    endtask

    initial begin
        bit acc;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single byte latency: accepted at edge 1, presented after edge 3.
        step(1'b1, 8'hAA, 1'b0, acc);
        chk("aa_accepted", 32'(acc), 32'(1));
        idle(2, 1'b0);
        @(negedge clk);
        chk("aa_out_valid", 32'(out_valid), 32'(1));
        chk("aa_out_data", 32'(out_data), 32'hAA);
        chk("aa_count", 32'(count), 32'(1));
        @(posedge clk); #1;

        // Fill to 17 and confirm the 18th byte is held.
        do_reset();
        for (int i = 0; i <= 16; i++) push(8'(i), 1'b0);
        idle(3, 1'b0);
        @(negedge clk);
        chk("full_flag", 32'(full), 32'(1));
        chk("full_count", 32'(count), 32'(17));
        chk("full_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h11, 1'b0, acc);
            chk("held_18th", 32'(acc), 32'(0));
        end

        // Drain in order, one byte every two cycles.
        idle(40, 1'b1);
        @(negedge clk);
        chk("drain_empty", 32'(empty), 32'(1));
        chk("drain_count", 32'(count), 32'(0));
        chk("drain_all_seen", 32'(m_stream.size()), 32'(0));
        @(posedge clk); #1;

        // Collision: read becomes due while upstream keeps offering.
        do_reset();
        step(1'b1, 8'h01, 1'b0, acc);
        step(1'b1, 8'h02, 1'b0, acc);
        chk("collision_blocked", 32'(acc), 32'(0));
        step(1'b1, 8'h02, 1'b0, acc);
        chk("collision_next_cycle", 32'(acc), 32'(1));
        idle(6, 1'b1);

        // Random interleave across several pointer wraps.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), acc);
        idle(40, 1'b1);
        chk("random_drained", 32'(m_stream.size()), 32'(0));
        chk("random_wrapped", 32'(wr_total > 40), 32'(1));

        // Reset mid-stream with 5 bytes held, then a fresh byte comes out first.
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 1'b0);
        idle(3, 1'b0);
        @(negedge clk);
        chk("pre_reset_count", 32'(count), 32'(5));
        @(posedge clk); #1;
        do_reset();
        push(8'h55, 1'b0);
        idle(2, 1'b0);
        @(negedge clk);
        chk("post_reset_byte", 32'(out_data), 32'h55);
        chk("post_reset_valid", 32'(out_valid), 32'(1));
        @(posedge clk); #1;
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
